// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ready handshake to instruction
// memory and presents {instruction, pc_plus_2} with a load enable to the IF/ID register.
module if_fetch_unit #(
  parameter int unsigned    W        = 16,
  parameter logic [W-1:0]   RESET_PC = '0,
  parameter logic [W-1:0]   NOP      = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  input  logic         imem_ready,
  output logic [W-1:0] instruction,
  output logic [W-1:0] pc_plus_2,
  output logic         out_valid,
  output logic         ifid_en
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [W-1:0] redir;
  logic [W-1:0] skid_instr;
  logic [W-1:0] skid_pc2;
  logic         started;

  logic [W-1:0] pc_inc;
  logic [W-1:0] tgt;
  logic         slot_free;

  assign pc_inc    = pc + W'(2);
  assign tgt       = branch_target & ~W'(1);
  assign slot_free = ~out_valid | ~stall;

  // started delays the first request to the edge after reset release
  assign imem_req  = started && (state != HOLD);
  assign imem_addr = pc;
  assign ifid_en   = out_valid & ~stall & ~branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redir       <= '0;
      skid_instr  <= '0;
      skid_pc2    <= '0;
      instruction <= NOP;
      pc_plus_2   <= '0;
      out_valid   <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (branch_taken) begin
            out_valid   <= 1'b0;
            instruction <= NOP;
            // no request outstanding (completed or never issued): redirect at once
            if (imem_ready || !started) begin
              pc <= tgt;
            end else begin
              redir <= tgt;
              state <= DRAIN;
            end
          end else if (imem_ready && started) begin
            pc <= pc_inc;
            if (slot_free) begin
              instruction <= imem_rdata;
              pc_plus_2   <= pc_inc;
              out_valid   <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc2   <= pc_inc;
              state      <= HOLD;
            end
          end else if (!stall) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            pc    <= branch_taken ? tgt : redir;
            state <= FETCH;
          end else if (branch_taken) begin
            redir <= tgt;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            out_valid   <= 1'b0;
            instruction <= NOP;
            pc          <= tgt;
            state       <= FETCH;
          end else if (!stall) begin
            instruction <= skid_instr;
            pc_plus_2   <= skid_pc2;
            out_valid   <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run
// checked against an in-order delivery model of the instruction stream.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, imem_ready;
  logic [15:0] branch_target, imem_rdata;
  logic        imem_req, out_valid, ifid_en;
  logic [15:0] imem_addr, instruction, pc_plus_2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // memory contents: word at address a is a ^ 16'hA000; junk when not ready
  always_comb imem_rdata = imem_ready ? (imem_addr ^ 16'hA000) : 16'hDEAD;

  if_fetch_unit #(.W(16), .RESET_PC(16'h0000), .NOP(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instruction(instruction),
    .pc_plus_2(pc_plus_2), .out_valid(out_valid), .ifid_en(ifid_en)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; branch_target = '0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1; branch_target = '0;
    #3;
    tests++;
    if ({out_valid, imem_req, instruction, pc_plus_2} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      fails++; $display("FAIL reset_state: got v=%b req=%b ins=%h p2=%h, want 0 0 0000 0000",
                        out_valid, imem_req, instruction, pc_plus_2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_req_before_edge: got %b want 0", imem_req);
    end
    step();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      fails++; $display("FAIL reset_first_req: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      tests++;
      if ({ifid_en, imem_addr} !== {(i > 0), 16'(2 * i)}) begin
        fails++; $display("FAIL stream_addr[%0d]: got en=%b addr=%h want %b %h",
                          i, ifid_en, imem_addr, (i > 0), 16'(2 * i));
      end
      step();
      tests++;
      if ({out_valid, instruction, pc_plus_2} !== {1'b1, 16'(2 * i) ^ 16'hA000, 16'(2 * i + 2)}) begin
        fails++; $display("FAIL stream_out[%0d]: got v=%b ins=%h p2=%h want 1 %h %h", i, out_valid,
                          instruction, pc_plus_2, 16'(2 * i) ^ 16'hA000, 16'(2 * i + 2));
      end
    end
  endtask

  task automatic test_wait_states;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      imem_ready = ((c % 4) == 3);
      #2;
      tests++;
      if ({imem_req, imem_addr} !== {1'b1, 16'(2 * (c / 4))}) begin
        fails++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want 1 %h",
                          c, imem_req, imem_addr, 16'(2 * (c / 4)));
      end
      step();
      tests++;
      if (out_valid !== ((c % 4) == 3)) begin
        fails++; $display("FAIL wait_valid[%0d]: got %b want %b", c, out_valid, ((c % 4) == 3));
      end
      if ((c % 4) == 3) begin
        tests++;
        if (pc_plus_2 !== 16'(2 * (c / 4) + 2)) begin
          fails++; $display("FAIL wait_pc2[%0d]: got %h want %h", c, pc_plus_2, 16'(2 * (c / 4) + 2));
        end
      end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_stall;
    logic [15:0] exp;
    do_reset();
    imem_ready = 1'b1;
    exp = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (ifid_en) begin
        tests++;
        if ({instruction, pc_plus_2} !== {exp ^ 16'hA000, exp + 16'd2}) begin
          fails++; $display("FAIL stall_pre[%0d]: got %h/%h want %h/%h", i, instruction, pc_plus_2,
                            exp ^ 16'hA000, exp + 16'd2);
        end
        exp = exp + 16'd2;
      end
      step();
    end
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #2;
      tests++;
      if (ifid_en !== 1'b0 || (s > 0 && imem_req !== 1'b0)) begin
        fails++; $display("FAIL stall_hold[%0d]: got en=%b req=%b want 0 0", s, ifid_en, imem_req);
      end
      step();
      tests++;
      if ({out_valid, instruction, pc_plus_2} !== {1'b1, exp ^ 16'hA000, exp + 16'd2}) begin
        fails++; $display("FAIL stall_frozen[%0d]: got v=%b %h/%h want 1 %h/%h", s, out_valid,
                          instruction, pc_plus_2, exp ^ 16'hA000, exp + 16'd2);
      end
    end
    stall = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #2;
      tests++;
      if ({ifid_en, instruction, pc_plus_2} !== {1'b1, exp ^ 16'hA000, exp + 16'd2}) begin
        fails++; $display("FAIL stall_resume[%0d]: got en=%b %h/%h want 1 %h/%h", r, ifid_en,
                          instruction, pc_plus_2, exp ^ 16'hA000, exp + 16'd2);
      end
      exp = exp + 16'd2;
      step();
    end
  endtask

  task automatic test_branch_pending;
    do_reset();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 16'h0041;
    #2;
    tests++;
    if (ifid_en !== 1'b0) begin
      fails++; $display("FAIL br_pend_en: got %b want 0", ifid_en);
    end
    step();
    branch_taken = 1'b0;
    tests++;
    if ({out_valid, instruction, imem_req, imem_addr} !== {1'b0, 16'h0000, 1'b1, 16'h0002}) begin
      fails++; $display("FAIL br_pend_flush: got v=%b ins=%h req=%b addr=%h want 0 0000 1 0002",
                        out_valid, instruction, imem_req, imem_addr);
    end
    step();
    imem_ready = 1'b1;
    #2;
    step();
    tests++;
    if ({out_valid, imem_addr} !== {1'b0, 16'h0040}) begin
      fails++; $display("FAIL br_pend_discard: got v=%b addr=%h want 0 0040", out_valid, imem_addr);
    end
    step();
    tests++;
    if ({out_valid, instruction, pc_plus_2} !== {1'b1, 16'hA040, 16'h0042}) begin
      fails++; $display("FAIL br_pend_target: got v=%b %h/%h want 1 A040/0042",
                        out_valid, instruction, pc_plus_2);
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_hold_branch_wrap;
    do_reset();
    imem_ready = 1'b1;
    step();
    stall = 1'b1;
    step();
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    #2;
    tests++;
    if ({imem_req, ifid_en} !== 2'b00) begin
      fails++; $display("FAIL hold_br_pre: got req=%b en=%b want 0 0", imem_req, ifid_en);
    end
    step();
    branch_taken = 1'b0; stall = 1'b0;
    tests++;
    if ({out_valid, instruction, imem_req, imem_addr} !== {1'b0, 16'h0000, 1'b1, 16'hFFFE}) begin
      fails++; $display("FAIL hold_br_flush: got v=%b ins=%h req=%b addr=%h want 0 0000 1 FFFE",
                        out_valid, instruction, imem_req, imem_addr);
    end
    step();
    tests++;
    if ({out_valid, instruction, pc_plus_2, imem_addr} !== {1'b1, 16'h5FFE, 16'h0000, 16'h0000}) begin
      fails++; $display("FAIL wrap: got v=%b ins=%h p2=%h addr=%h want 1 5FFE 0000 0000",
                        out_valid, instruction, pc_plus_2, imem_addr);
    end
    step();
    tests++;
    if ({instruction, pc_plus_2} !== {16'hA000, 16'h0002}) begin
      fails++; $display("FAIL skid_dropped: got %h/%h want A000/0002", instruction, pc_plus_2);
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 16'h0080;
    step();
    branch_taken = 1'b0;
    tests++;
    if ({imem_req, imem_addr, pc_plus_2} !== {1'b1, 16'h0002, 16'h0002}) begin
      fails++; $display("FAIL drain_state: got req=%b addr=%h p2=%h want 1 0002 0002",
                        imem_req, imem_addr, pc_plus_2);
    end
    step();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, imem_req, instruction, pc_plus_2, ifid_en} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
      fails++; $display("FAIL async_reset: got v=%b req=%b ins=%h p2=%h en=%b want 0 0 0000 0000 0",
                        out_valid, imem_req, instruction, pc_plus_2, ifid_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      fails++; $display("FAIL restart_addr: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, instruction, pc_plus_2} !== {1'b1, 16'hA000, 16'h0002}) begin
      fails++; $display("FAIL restart_out: got v=%b %h/%h want 1 A000/0002",
                        out_valid, instruction, pc_plus_2);
    end
    imem_ready = 1'b0;
  endtask

  // Model: consumers see consecutive addresses; a branch restarts the stream at its target.
  task automatic test_random;
    logic [15:0] exp, prev_addr;
    logic        prev_pending;
    int          delivered;
    logic        got;
    do_reset();
    exp = 16'h0000; prev_pending = 1'b0; prev_addr = '0; delivered = 0;
    for (int c = 0; c < 400; c++) begin
      stall         = ($urandom % 4) == 0;
      imem_ready    = ($urandom % 3) != 0;
      branch_taken  = ($urandom % 16) == 0;
      branch_target = 16'($urandom);
      #2;
      if (prev_pending) begin
        tests++;
        if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
          fails++; $display("FAIL rnd_req_stable[%0d]: got req=%b addr=%h want 1 %h",
                            c, imem_req, imem_addr, prev_addr);
        end
      end
      prev_pending = imem_req && !imem_ready;
      prev_addr    = imem_addr;
      if (ifid_en) begin
        tests++;
        if ({instruction, pc_plus_2} !== {exp ^ 16'hA000, exp + 16'd2}) begin
          fails++; $display("FAIL rnd_deliver[%0d]: got %h/%h want %h/%h", c, instruction,
                            pc_plus_2, exp ^ 16'hA000, exp + 16'd2);
        end
        delivered++;
      end
      if (branch_taken) exp = branch_target & 16'hFFFE;
      else if (ifid_en) exp = exp + 16'd2;
      step();
    end
    stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #2;
      if (ifid_en) begin
        got = 1'b1;
        tests++;
        if ({instruction, pc_plus_2} !== {exp ^ 16'hA000, exp + 16'd2}) begin
          fails++; $display("FAIL rnd_final: got %h/%h want %h/%h", instruction, pc_plus_2,
                            exp ^ 16'hA000, exp + 16'd2);
        end
      end
      step();
    end
    tests++;
    if (!got || delivered < 20) begin
      fails++; $display("FAIL rnd_progress: got final=%b delivered=%0d want 1 and >=20", got, delivered);
    end
    imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_branch_pending();
    test_hold_branch_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
